// File: rtl/pipelined_core_il.sv
// pipelined_core_il: 5-stage IF/ID/EX/MEM/WB core with a unified memory.
// It has EX forwarding, a load-use interlock and a taken-branch flush.
package pipelined_core_il_pkg;
  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_SLT   = 6'd4;
  localparam logic [5:0] OP_MUL   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd8;
  localparam logic [5:0] OP_SW    = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd10;
  localparam logic [5:0] OP_SUBI  = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_BNEQZ = 6'd13;
  localparam logic [5:0] OP_BEQZ  = 6'd14;
  localparam logic [5:0] OP_HLT   = 6'd63;
endpackage

module pipelined_core_il
  import pipelined_core_il_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [XLEN-1:0]   load_data,
  input  logic              start,
  input  logic [MEM_AW-1:0] start_pc,
  output logic [XLEN-1:0]   rd_data,
  output logic              busy,
  output logic              halted
);

  typedef logic [MEM_AW-1:0] addr_t;
  typedef logic [XLEN-1:0]   word_t;

  typedef struct packed {
    logic        v;
    logic [31:0] ins;
    addr_t       pc;
  } if_id_t;

  typedef struct packed {
    logic       v;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       we;
    logic [4:0] wd;
    word_t      a;
    word_t      b;
    word_t      imm;
    addr_t      pc;
  } id_ex_t;

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] wd;
    word_t      res;
    logic       lw;
    logic       sw;
    word_t      sd;
    logic       hlt;
  } ex_mem_t;

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] wd;
    word_t      res;
    logic       hlt;
  } mem_wb_t;

  word_t   mem [2**MEM_AW];
  word_t   rf  [32];
  addr_t   pc;
  logic    stop;
  logic    hq;
  if_id_t  ifid;
  id_ex_t  idex;
  id_ex_t  idex_n;
  ex_mem_t exm;
  ex_mem_t exm_n;
  mem_wb_t mwb;
  mem_wb_t mwb_n;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        rr;
  logic        rm;
  logic        use_rs;
  logic        use_rt;
  logic        stall;
  logic        id_hlt;
  word_t       fa;
  word_t       fb;
  word_t       alu;
  logic        take;
  addr_t       tgt;
  addr_t       ea;
  logic [31:0] ins_f;

  // Youngest in-flight result for register r wins; loads in MEM cannot forward.
  function automatic word_t fwd(input logic [4:0] r, input word_t d,
                                input ex_mem_t e, input mem_wb_t w);
    word_t v;
    v = d;
    if (e.v && e.we && !e.lw && e.wd == r)
      v = e.res;
    else if (w.v && w.we && w.wd == r)
      v = w.res;
    return v;
  endfunction

  assign rd_data = mem[load_addr];
  assign ins_f   = mem[pc][31:0];
  assign ea      = exm.res[MEM_AW-1:0];

  // Decode, register read with WB write-through, load-use detection.
  always_comb begin
    op     = ifid.ins[31:26];
    rs     = ifid.ins[25:21];
    rt     = ifid.ins[20:16];
    rd     = ifid.ins[15:11];
    rr     = op <= OP_MUL;
    rm     = op == OP_ADDI || op == OP_SUBI || op == OP_SLTI;
    use_rs = rr || rm || op == OP_LW || op == OP_SW ||
             op == OP_BNEQZ || op == OP_BEQZ;
    use_rt = rr || op == OP_SW;
    idex_n     = '0;
    idex_n.v   = ifid.v;
    idex_n.op  = op;
    idex_n.rs  = rs;
    idex_n.rt  = rt;
    idex_n.wd  = rr ? rd : rt;
    idex_n.we  = ifid.v && (rr || rm || op == OP_LW) && idex_n.wd != 5'd0;
    idex_n.imm = {{(XLEN-16){ifid.ins[15]}}, ifid.ins[15:0]};
    idex_n.pc  = ifid.pc;
    if (rs == 5'd0)
      idex_n.a = '0;
    else if (mwb.v && mwb.we && mwb.wd == rs)
      idex_n.a = mwb.res;
    else
      idex_n.a = rf[rs];
    if (rt == 5'd0)
      idex_n.b = '0;
    else if (mwb.v && mwb.we && mwb.wd == rt)
      idex_n.b = mwb.res;
    else
      idex_n.b = rf[rt];
    stall  = ifid.v && idex.v && idex.we && idex.op == OP_LW &&
             ((use_rs && idex.wd == rs) || (use_rt && idex.wd == rt));
    id_hlt = ifid.v && op == OP_HLT;
  end

  // Execute: forwarded operands, ALU and branch resolution.
  always_comb begin
    fa  = fwd(idex.rs, idex.a, exm, mwb);
    fb  = fwd(idex.rt, idex.b, exm, mwb);
    alu = '0;
    case (idex.op)
      OP_ADD:  alu = fa + fb;
      OP_SUB:  alu = fa - fb;
      OP_AND:  alu = fa & fb;
      OP_OR:   alu = fa | fb;
      OP_SLT:  alu = {{(XLEN-1){1'b0}}, $signed(fa) < $signed(fb)};
      OP_MUL:  alu = fa * fb;
      OP_ADDI: alu = fa + idex.imm;
      OP_SUBI: alu = fa - idex.imm;
      OP_SLTI: alu = {{(XLEN-1){1'b0}}, $signed(fa) < $signed(idex.imm)};
      OP_LW:   alu = fa + idex.imm;
      OP_SW:   alu = fa + idex.imm;
      default: alu = '0;
    endcase
    take = idex.v &&
           ((idex.op == OP_BNEQZ && fa != '0) ||
            (idex.op == OP_BEQZ && fa == '0));
    tgt  = idex.pc + addr_t'(1) + idex.imm[MEM_AW-1:0];
    exm_n     = '0;
    exm_n.v   = idex.v;
    exm_n.we  = idex.we;
    exm_n.wd  = idex.wd;
    exm_n.res = alu;
    exm_n.lw  = idex.v && idex.op == OP_LW;
    exm_n.sw  = idex.v && idex.op == OP_SW;
    exm_n.sd  = fb;
    exm_n.hlt = idex.v && idex.op == OP_HLT;
  end

  // Memory stage: loads read the unified memory combinationally.
  always_comb begin
    mwb_n     = '0;
    mwb_n.v   = exm.v;
    mwb_n.we  = exm.we;
    mwb_n.wd  = exm.wd;
    mwb_n.res = exm.lw ? mem[ea] : exm.res;
    mwb_n.hlt = exm.hlt;
  end

  // Unified memory: pipeline store first, host writes only when idle.
  always_ff @(posedge clk) begin
    if (exm.v && exm.sw)
      mem[ea] <= exm.sd;
    else if (load_en && !busy)
      mem[load_addr] <= load_data;
  end

  // Register file, written in WB; R0 is never a write target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= '0;
    end else if (mwb.v && mwb.we) begin
      rf[mwb.wd] <= mwb.res;
    end
  end

  // PC, pipeline registers and run control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= '0;
      ifid   <= '0;
      idex   <= '0;
      exm    <= '0;
      mwb    <= '0;
      busy   <= 1'b0;
      halted <= 1'b0;
      stop   <= 1'b0;
      hq     <= 1'b0;
    end else if (start && !busy) begin
      pc     <= start_pc;
      ifid   <= '0;
      idex   <= '0;
      exm    <= '0;
      mwb    <= '0;
      busy   <= 1'b1;
      halted <= 1'b0;
      stop   <= 1'b0;
      hq     <= 1'b0;
    end else begin
      exm <= exm_n;
      mwb <= mwb_n;
      hq  <= mwb.v && mwb.hlt;
      if (hq) begin
        busy   <= 1'b0;
        halted <= 1'b1;
      end
      if (take) begin
        pc   <= tgt;
        ifid <= '0;
        idex <= '0;
        stop <= 1'b0;
      end else if (stall) begin
        idex <= '0;
      end else begin
        idex <= idex_n;
        if (id_hlt) begin
          ifid <= '0;
          stop <= 1'b1;
        end else if (busy && !stop) begin
          ifid <= {1'b1, ins_f, pc};
          pc   <= pc + addr_t'(1);
        end else begin
          ifid <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_core_il.sv
// tb_pipelined_core_il: directed programs for pipelined_core_il.
// Each scenario task loads code, runs it and checks memory and timing.
module tb_pipelined_core_il;
  localparam int XLEN = 32;
  localparam int AW   = 10;

  localparam logic [5:0] ADD   = 6'd0;
  localparam logic [5:0] SUB   = 6'd1;
  localparam logic [5:0] SLT   = 6'd4;
  localparam logic [5:0] MUL   = 6'd5;
  localparam logic [5:0] LW    = 6'd8;
  localparam logic [5:0] SW    = 6'd9;
  localparam logic [5:0] ADDI  = 6'd10;
  localparam logic [5:0] SUBI  = 6'd11;
  localparam logic [5:0] SLTI  = 6'd12;
  localparam logic [5:0] BNEQZ = 6'd13;
  localparam logic [31:0] HLT  = 32'hfc00_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            load_en;
  logic [AW-1:0]   load_addr;
  logic [XLEN-1:0] load_data;
  logic            start;
  logic [AW-1:0]   start_pc;
  logic [XLEN-1:0] rd_data;
  logic            busy;
  logic            halted;

  int passed = 0;
  int total  = 0;
  logic [31:0] prog[$];

  always #5 clk = ~clk;

  pipelined_core_il #(.XLEN(XLEN), .MEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .start_pc(start_pc),
    .rd_data(rd_data), .busy(busy), .halted(halted)
  );

  function automatic logic [31:0] rr(input logic [5:0] op,
                                     input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op,
                                     input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  task automatic peek(input int a, output logic [31:0] d);
    load_addr = AW'(a);
    #1;
    d = rd_data;
  endtask

  task automatic load_prog(input int base);
    foreach (prog[i]) poke(base + i, prog[i]);
    prog.delete();
  endtask

  // Pulse start at a falling edge and count rising edges until halted.
  task automatic run(input int spc, input int maxc, output int edges);
    int n;
    @(negedge clk);
    start    = 1'b1;
    start_pc = AW'(spc);
    @(negedge clk);
    start = 1'b0;
    edges = -1;
    n = 0;
    while (n < maxc && edges < 0) begin
      @(negedge clk);
      n++;
      if (halted) edges = n;
    end
  endtask

  task automatic test_reset();
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else passed++;
    total++;
    if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted);
    else passed++;
  endtask

  task automatic test_load_add_store();
    int e;
    logic [31:0] v;
    prog.push_back(ri(ADDI, 1, 0, 120));
    prog.push_back(ri(LW, 2, 1, 0));
    prog.push_back(ri(ADDI, 2, 2, 45));
    prog.push_back(ri(SW, 2, 1, 1));
    prog.push_back(HLT);
    load_prog(0);
    poke(120, 85);
    poke(121, 0);
    run(0, 200, e);
    total++;
    if (e !== 11) $display("FAIL las_edges: got %0d want 11", e);
    else passed++;
    peek(121, v);
    total++;
    if (v !== 32'd130) $display("FAIL las_mem121: got %0d want 130", v);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL las_busy: got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_forwarding();
    int e;
    logic [31:0] v;
    prog.push_back(ri(ADDI, 1, 0, 5));
    prog.push_back(rr(ADD, 2, 1, 1));
    prog.push_back(rr(SUB, 3, 2, 1));
    prog.push_back(rr(MUL, 4, 3, 2));
    prog.push_back(ri(SW, 4, 0, 200));
    prog.push_back(HLT);
    load_prog(10);
    poke(200, 0);
    run(10, 200, e);
    total++;
    if (e !== 11) $display("FAIL fwd_edges: got %0d want 11", e);
    else passed++;
    peek(200, v);
    total++;
    if (v !== 32'd50) $display("FAIL fwd_mem200: got %0d want 50", v);
    else passed++;
  endtask

  task automatic test_branch_loop();
    int e;
    logic [31:0] v;
    prog.push_back(ri(ADDI, 1, 0, 7));
    prog.push_back(ri(ADDI, 2, 0, 1));
    prog.push_back(ri(ADDI, 10, 0, 0));
    prog.push_back(rr(MUL, 2, 2, 1));
    prog.push_back(ri(SUBI, 1, 1, 1));
    prog.push_back(ri(BNEQZ, 0, 1, -3));
    prog.push_back(ri(ADDI, 10, 10, 1));
    prog.push_back(ri(SW, 2, 0, 300));
    prog.push_back(ri(SW, 10, 0, 301));
    prog.push_back(HLT);
    load_prog(20);
    poke(300, 0);
    poke(301, 77);
    run(20, 300, e);
    total++;
    if (e !== 45) $display("FAIL loop_edges: got %0d want 45", e);
    else passed++;
    peek(300, v);
    total++;
    if (v !== 32'd5040) $display("FAIL loop_fact: got %0d want 5040", v);
    else passed++;
    peek(301, v);
    total++;
    if (v !== 32'd1) $display("FAIL loop_shadow: got %0d want 1", v);
    else passed++;
  endtask

  task automatic test_r0_slt();
    int e;
    logic [31:0] v;
    logic [31:0] want [5];
    want = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
    prog.push_back(ri(ADDI, 7, 0, -3));
    prog.push_back(ri(ADDI, 0, 0, 9));
    prog.push_back(ri(SLTI, 5, 0, -1));
    prog.push_back(rr(SLT, 6, 0, 7));
    prog.push_back(rr(SLT, 8, 7, 0));
    prog.push_back(ri(SLTI, 11, 7, -2));
    prog.push_back(ri(SW, 0, 0, 400));
    prog.push_back(ri(SW, 5, 0, 401));
    prog.push_back(ri(SW, 6, 0, 402));
    prog.push_back(ri(SW, 8, 0, 403));
    prog.push_back(ri(SW, 11, 0, 404));
    prog.push_back(HLT);
    load_prog(40);
    for (int i = 0; i < 5; i++) poke(400 + i, 77);
    run(40, 200, e);
    total++;
    if (e !== 17) $display("FAIL slt_edges: got %0d want 17", e);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      peek(400 + i, v);
      total++;
      if (v !== want[i])
        $display("FAIL slt_mem%0d: got %0d want %0d", 400 + i, v, want[i]);
      else passed++;
    end
  endtask

  task automatic load_loop();
    prog.push_back(ri(ADDI, 1, 0, 200));
    prog.push_back(ri(SUBI, 1, 1, 1));
    prog.push_back(ri(BNEQZ, 0, 1, -2));
    prog.push_back(ri(SW, 1, 0, 500));
    prog.push_back(HLT);
    load_prog(60);
  endtask

  task automatic test_protocol();
    int n;
    logic [31:0] v;
    load_loop();
    poke(500, 7);
    poke(510, 11);
    @(negedge clk);
    start    = 1'b1;
    start_pc = AW'(60);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n++;
    end
    load_en   = 1'b1;
    load_addr = AW'(510);
    load_data = 32'd999;
    @(negedge clk);
    n++;
    load_en  = 1'b0;
    start    = 1'b1;
    start_pc = AW'(0);
    @(negedge clk);
    n++;
    start = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL proto_busy: got %b want 1", busy);
    else passed++;
    while (!halted && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 806) $display("FAIL proto_edges: got %0d want 806", n);
    else passed++;
    peek(510, v);
    total++;
    if (v !== 32'd11) $display("FAIL proto_hostwr: got %0d want 11", v);
    else passed++;
    peek(500, v);
    total++;
    if (v !== 32'd0) $display("FAIL proto_mem500: got %0d want 0", v);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    int e;
    logic [31:0] v;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (halted !== 1'b0) $display("FAIL rst_halted_clr: got %b want 0", halted);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    poke(500, 7);
    @(negedge clk);
    start    = 1'b1;
    start_pc = AW'(60);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy);
    else passed++;
    total++;
    if (halted !== 1'b0) $display("FAIL rst_mid_halted: got %b want 0", halted);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    peek(500, v);
    total++;
    if (v !== 32'd7) $display("FAIL rst_mem500: got %0d want 7", v);
    else passed++;
    poke(200, 0);
    run(10, 200, e);
    total++;
    if (e !== 11) $display("FAIL rst_rerun_edges: got %0d want 11", e);
    else passed++;
    peek(200, v);
    total++;
    if (v !== 32'd50) $display("FAIL rst_rerun_mem: got %0d want 50", v);
    else passed++;
  endtask

  initial begin
    rst       = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    start     = 1'b0;
    start_pc  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_load_add_store();
    test_forwarding();
    test_branch_loop();
    test_r0_slt();
    test_protocol();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipelined_core_il.md
# pipelined_core_il

Single-clock, parametrised successor of the two-phase `pipelined_processor`. It is a 5-stage IF/ID/EX/MEM/WB core on the same 32-bit instruction encoding, with hardware hazard handling: EX-stage forwarding, a one-cycle load-use interlock and a taken-branch flush. Programs run without dummy instructions. A host port loads the unified instruction/data memory, starts execution and reads results back. The block sits under the system testbench in place of the hand-poked memory/register arrays.

## Interface
- `XLEN`, 32: data width, ≥32; register file, ALU and data words are XLEN bits; instruction words use bits [31:0].
- `MEM_AW`, 10: word-address width of the unified memory (depth 2^MEM_AW).
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load_en` in 1: host write to memory; honoured only while `busy`=0.
- `load_addr` in MEM_AW: host write/read word address.
- `load_data` in XLEN: host write data.
- `start` in 1: one-cycle pulse; ignored while `busy`=1.
- `start_pc` in MEM_AW: first instruction address, sampled with `start`.
- `rd_data` out XLEN: combinational `mem[load_addr]`.
- `busy` out 1: core executing.
- `halted` out 1: sticky; HLT has retired.

## Operation
- Reset values: PC, all pipeline registers and R0..R31 = 0; `busy`=0; `halted`=0; all stages hold bubbles. Memory contents are not reset.
- Encoding: op[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0], sign-extended to XLEN.
- RR ops, rd ← rs op rt:
  - ADD 000000, SUB 000001, AND 000010, OR 000011.
  - SLT 000100 (signed, result 1/0).
  - MUL 000101 (low XLEN bits).
- RM ops, rt ← rs op imm: ADDI 001010, SUBI 001011, SLTI 001100.
- Memory ops:
  - LW 001000: rt ← mem[rs+imm].
  - SW 001001: mem[rs+imm] ← rt.
  - Effective address uses the low MEM_AW bits, so addresses wrap.
- Branches:
  - BNEQZ 001101 and BEQZ 001110 test rs.
  - Target = PC_of_branch + 1 + imm.
  - Resolved in EX. A taken branch flushes the two younger instructions (IF, ID) to bubbles.
- HLT is 111111. Any other opcode executes as a NOP.
- Writes to R0 are discarded; R0 always reads 0.
- Register file:
  - Written in WB, read in ID.
  - Same-cycle WB write to the register being read bypasses to ID (write-through).
- Forwarding into EX: priority EX/MEM result over MEM/WB result over ID value. Loads forward only from MEM/WB.
- Load-use interlock: when the instruction in EX is LW with rt equal to a source of the ID instruction (rs, or rt for RR/SW), PC and IF/ID hold for one cycle and a bubble is injected into EX.
- HLT:
  - When HLT is in ID, fetch stops. The already-fetched younger instruction is squashed.
  - When HLT reaches WB: `busy`←0 and `halted`←1.
  - A taken branch in EX at the same time as HLT in ID flushes the HLT, and execution continues.
- Start: `start` while `busy`=0 loads PC←`start_pc`, sets `busy`=1, clears `halted`, and flushes the pipeline. Registers are not cleared.
- Host `load_en` while `busy`=1 is dropped without effect.
- Memory read (IF, MEM) is combinational. Writes (SW in MEM, host) happen at the clock edge.
- Reset mid-run aborts immediately to the reset state. Memory writes already committed remain.

## Timing
- Count the `start` edge as edge 0. Instruction i (straight-line) is fetched in the cycle after edge i.
- With HLT at index k, `halted` rises at edge k+6, plus 1 per load-use stall and 2 per taken branch.
- Throughput is 1 instruction per cycle absent hazards.
- A SW committed at an edge is visible on `rd_data` in the following cycle.

## Test plan
- Load-add-store, no dummies:
  - Program: ADDI R1,R0,120; LW R2,0(R1); ADDI R2,R2,45; SW R2,1(R1); HLT. Preload mem[120]=85.
  - Expect mem[121]=130, with `halted` at edge 11 (one stall).
- Forwarding chain:
  - Program: ADDI R1,R0,5; ADD R2,R1,R1; SUB R3,R2,R1; MUL R4,R3,R2; SW R4,200(R0); HLT.
  - Expect mem[200]=50, with `halted` at edge 11 (no stalls).
- Branch loop:
  - Program: factorial of 7 using BNEQZ with a back-branch.
  - Expect the stored result 5040. Expect the two instructions after each taken branch never to write.
- R0 and SLT:
  - Program: ADDI R0,R0,9; SLTI R5,R0,-1; SLT R6,R0,R7 (R7 set to -3).
  - Expect R0 still 0, R5=0, R6=0.
- Reset and protocol:
  - Assert `rst` mid-run. Expect `busy`=0, `halted`=0 immediately.
  - Issue `load_en` during a run. Expect the target word unchanged.
  - Issue a second `start` while busy. Expect it ignored.
